// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the streaming matrix multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    localparam int N_DEF  = 3;
    localparam int DW_DEF = 8;

    // Accumulator width that can hold the sum of n full-width dw x dw products.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Registered multiply-accumulate: acc <= clr ? 0 : en ? acc + a*b : acc.
// Latency: 1 cycle from operands to updated accumulator.
// Backpressure: none; the caller gates progress with en.
module matmul_mac_unit #(
    parameter int DW = 8,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [2*DW-1:0] prod;

    // Next accumulator value: clear wins over accumulate; product zero-extended.
    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matmul_stream_engine.sv
// N x N unsigned matrix multiply C = A x B; operands streamed in, results streamed out row-major.
// Latency: 2*N*N load beats, then per element N MAC cycles (fewer with MATMUL_ZERO_SKIP_EN) + 1 output cycle.
// Backpressure: in_ready only in LOAD; out_valid/out_data held until out_ready accepts.
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = acc_width(N, DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          out_last,
    output logic [15:0]   mac_cycles
);

    localparam int NN  = N * N;
    localparam int IW  = $clog2(N);
    localparam int AIW = $clog2(NN);
    localparam int LIW = $clog2(2 * NN);

    state_t         state_q, state_d;
    logic [LIW-1:0] ld_idx_q, ld_idx_d;
    logic [IW-1:0]  r_q, r_d;
    logic [IW-1:0]  c_q, c_d;
    logic [IW-1:0]  k_q, k_d;
    logic [15:0]    mac_cnt_q, mac_cnt_d;

    // Operand storage; not reset, every job reloads it completely.
    logic [DW-1:0]  a_q [NN];
    logic [DW-1:0]  b_q [NN];

    logic           ld_fire;
    logic           ld_is_a;
    logic [AIW-1:0] b_wr_idx;
    logic [AIW-1:0] a_rd_idx;
    logic [AIW-1:0] b_rd_idx;
    logic           last_elem;
    logic           mac_clr;
    logic           mac_en;
    logic           enter_compute;

    assign ld_fire   = (state_q == LOAD) && in_valid;
    assign ld_is_a   = ld_idx_q < LIW'(NN);
    assign b_wr_idx  = AIW'(ld_idx_q - LIW'(NN));
    assign a_rd_idx  = AIW'(r_q) * AIW'(N) + AIW'(k_q);
    assign b_rd_idx  = AIW'(k_q) * AIW'(N) + AIW'(c_q);
    assign last_elem = (r_q == IW'(N - 1)) && (c_q == IW'(N - 1));

`ifdef MATMUL_ZERO_SKIP_EN
    logic [N-1:0]  row_nz;
    logic          skip_found;
    logic [IW-1:0] skip_idx;

    // Next nonzero A[r][j] strictly after the current k (lowest index wins).
    always_comb begin
        row_nz     = '0;
        skip_found = 1'b0;
        skip_idx   = '0;
        for (int j = 0; j < N; j++) begin
            row_nz[j] = (a_q[AIW'(r_q) * AIW'(N) + AIW'(j)] != '0);
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (row_nz[j] && (IW'(j) > k_q)) begin
                skip_found = 1'b1;
                skip_idx   = IW'(j);
            end
        end
    end
`endif

    // FSM next state, index counters, MAC control and cycle counter.
    always_comb begin
        state_d       = state_q;
        ld_idx_d      = ld_idx_q;
        r_d           = r_q;
        c_d           = c_q;
        k_d           = k_q;
        mac_cnt_d     = mac_cnt_q;
        mac_clr       = 1'b0;
        mac_en        = 1'b0;
        enter_compute = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    ld_idx_d  = '0;
                    mac_cnt_d = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    ld_idx_d = ld_idx_q + LIW'(1);
                    if (ld_idx_q == LIW'(2 * NN - 1)) begin
                        state_d       = COMPUTE;
                        r_d           = '0;
                        c_d           = '0;
                        mac_clr       = 1'b1;
                        enter_compute = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                mac_en = 1'b1;
                if (mac_cnt_q != 16'hFFFF) begin
                    mac_cnt_d = mac_cnt_q + 16'd1;
                end
`ifdef MATMUL_ZERO_SKIP_EN
                if (skip_found) begin
                    k_d = skip_idx;
                end else begin
                    state_d = OUTPUT;
                end
`else
                if (k_q == IW'(N - 1)) begin
                    state_d = OUTPUT;
                end else begin
                    k_d = k_q + IW'(1);
                end
`endif
            end
            OUTPUT: begin
                if (out_ready) begin
                    if (last_elem) begin
                        state_d = IDLE;
                    end else begin
                        state_d       = COMPUTE;
                        mac_clr       = 1'b1;
                        enter_compute = 1'b1;
                        if (c_q == IW'(N - 1)) begin
                            c_d = '0;
                            r_d = r_q + IW'(1);
                        end else begin
                            c_d = c_q + IW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Starting k for the element about to be computed (row r_d).
        if (enter_compute) begin
            k_d = '0;
`ifdef MATMUL_ZERO_SKIP_EN
            for (int j = N - 1; j >= 0; j--) begin
                if (a_q[AIW'(r_d) * AIW'(N) + AIW'(j)] != '0) begin
                    k_d = IW'(j);
                end
            end
`endif
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ld_idx_q  <= '0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            mac_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_idx_q  <= ld_idx_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            mac_cnt_q <= mac_cnt_d;
        end
    end

    // Operand write port: first N*N beats fill A, the next N*N fill B.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            if (ld_is_a) begin
                a_q[ld_idx_q[AIW-1:0]] <= in_data;
            end else begin
                b_q[b_wr_idx] <= in_data;
            end
        end
    end

    matmul_mac_unit #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (a_q[a_rd_idx]),
        .b   (b_q[b_rd_idx]),
        .acc (out_data)
    );

    assign busy       = (state_q != IDLE);
    assign in_ready   = (state_q == LOAD);
    assign out_valid  = (state_q == OUTPUT);
    assign out_last   = (state_q == OUTPUT) && last_elem;
    assign done       = (state_q == OUTPUT) && out_ready && last_elem;
    assign mac_cycles = mac_cnt_q;

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Scoreboard bench for matmul_stream_engine (N=3, DW=8): directed jobs, decoupled output monitor.
// Latency: checks job latency with out_ready held high.
// Backpressure: drives out_ready high or with a pseudo-random 1-0-0-1 pattern.
module tb_matmul_stream_engine;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 2 * DW + $clog2(N);

`ifdef MATMUL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b1;
    logic          busy, done, in_ready, out_valid, out_last;
    logic [AW-1:0] out_data;
    logic [15:0]   mac_cycles;

    always #5 clk = ~clk;

    matmul_stream_engine #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .mac_cycles (mac_cycles)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    typedef struct packed {
        logic [AW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_acc  = 0;
    int   n_done = 0;

    // Output monitor: pops the scoreboard on every accepted result.
    initial begin
        logic          stalled;
        logic [AW-1:0] held_data;
        logic          held_last;
        exp_t          e;
        stalled   = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("valid_held", out_valid, 1);
                    if (out_valid) begin
                        check("data_stable", out_data, held_data);
                        check("last_stable", out_last, held_last);
                    end
                end
                stalled = 1'b0;
                if (out_valid && out_ready) begin
                    check("scoreboard_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("out_data[%0d]", n_acc), out_data, e.data);
                        check($sformatf("out_last[%0d]", n_acc), out_last, e.last);
                        check("done_with_last", done, out_last);
                    end
                    n_acc++;
                end else if (out_valid) begin
                    stalled   = 1'b1;
                    held_data = out_data;
                    held_last = out_last;
                end
                if (done) begin
                    check("done_only_on_accept", out_valid && out_ready, 1);
                    n_done++;
                end
            end
        end
    end

    // out_ready driver: mode 0 always ready, mode 1 walks a 1-0-0-1 pattern at random strides.
    int rdy_mode = 0;
    initial begin
        logic [3:0] pat;
        int         ph;
        pat = 4'b1001;
        ph  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = pat[ph];
                ph = (ph + int'($urandom_range(1, 2))) % 4;
            end
        end
    end

    logic [DW-1:0] a_v [9];
    logic [DW-1:0] b_v [9];
    logic [AW-1:0] c_v [9];

    task automatic push_expected();
        for (int i = 0; i < 9; i++) exp_q.push_back('{data: c_v[i], last: (i == 8)});
    endtask

    task automatic do_start(input string tag);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_in_ready_load"}, in_ready, 1);
        check({tag, "_mac_cleared"}, mac_cycles, 0);
    endtask

    task automatic do_load(input string tag, input bit gaps);
        for (int i = 0; i < 18; i++) begin
            if (gaps && (i % 4 == 1)) begin
                in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check({tag, "_busy_in_gap"}, busy, 1);
            end
            in_valid = 1'b1;
            in_data  = (i < 9) ? a_v[i] : b_v[i - 9];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({tag, "_in_ready_after_load"}, in_ready, 0);
    endtask

    task automatic wait_done(input string tag, input int acc0, input int done0,
                             input int exp_mac, input int exp_lat, input bit restart);
        int cyc;
        cyc = 0;
        while (busy && cyc < 2000) begin
            start = (restart && cyc == 5);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_finished_in_budget"}, busy, 0);
        if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_results_accepted"}, n_acc - acc0, 9);
        check({tag, "_done_pulses"}, n_done - done0, 1);
        check({tag, "_mac_cycles"}, mac_cycles, exp_mac);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_mac_cycles_hold"}, mac_cycles, exp_mac);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic run_job(input string tag, input int exp_mac, input int exp_lat,
                           input bit gaps, input bit restart);
        int acc0, done0;
        acc0  = n_acc;
        done0 = n_done;
        push_expected();
        do_start(tag);
        do_load(tag, gaps);
        wait_done(tag, acc0, done0, exp_mac, exp_lat, restart);
    endtask

    initial begin
        int acc0, cyc;

        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mac_cycles", mac_cycles, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Identity A, B = 1..9
        a_v = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        b_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        c_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_job("ident", SKIP ? 9 : 27, SKIP ? 18 : 36, 1'b0, 1'b0);

        // Full-scale operands: no truncation of the 18-bit result
        a_v = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        b_v = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        c_v = '{195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075};
        run_job("full", 27, 36, 1'b0, 1'b0);

        // Output backpressure
        a_v = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        b_v = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
        c_v = '{18, 18, 18, 18, 18, 18, 18, 18, 18};
        rdy_mode = 1;
        run_job("stall", 27, -1, 1'b0, 1'b0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        // Load gaps and a start pulse mid-compute
        a_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        b_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        c_v = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        run_job("gaps", 27, 36, 1'b1, 1'b1);

        // Reset in COMPUTE after four results
        a_v = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        b_v = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
        c_v = '{18, 18, 18, 18, 18, 18, 18, 18, 18};
        acc0 = n_acc;
        push_expected();
        do_start("abort");
        do_load("abort", 1'b0);
        cyc = 0;
        while ((n_acc - acc0) < 4 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_four_results", n_acc - acc0, 4);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_last", out_last, 0);
        check("abort_out_data", out_data, 0);
        check("abort_mac_cycles", mac_cycles, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        a_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        b_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        c_v = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        run_job("reload", 27, 36, 1'b0, 1'b0);

        // Diagonal A: sparse rows
        a_v = '{1, 0, 0, 0, 2, 0, 0, 0, 3};
        b_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        c_v = '{1, 2, 3, 8, 10, 12, 21, 24, 27};
        run_job("diag", SKIP ? 9 : 27, SKIP ? 18 : 36, 1'b0, 1'b0);

        // All-zero first row, one- and two-nonzero rows
        a_v = '{0, 0, 0, 0, 5, 0, 1, 0, 1};
        b_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        c_v = '{0, 0, 0, 20, 25, 30, 8, 10, 12};
        run_job("zrow", SKIP ? 12 : 27, SKIP ? 21 : 36, 1'b0, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matmul_stream_engine.md
Name: matmul_stream_engine

Overview:
- Parametrised N x N unsigned integer matrix multiplier, C = A x B.
- Operands are loaded over a valid/ready stream into internal register arrays.
- A single MAC unit computes each result element, and results leave on a valid/ready stream in row-major order.
- Generalises the fixed 3x3, 8-bit, truncating multiplier: adds configurable size, full-precision outputs, flow control and a done/busy handshake.

Parameters:
- N, 3, matrix dimension (2..16).
- DW, 8, operand element width in bits.
- AW, 2*DW+$clog2(N), accumulator and result width; full precision, never truncated.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load/compute job; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse on the cycle the last result is accepted.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  DW  operand element: A row-major (N*N beats), then B row-major (N*N beats).
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  AW  C[r][c], row-major.
- out_last  out  1  qualifies the final element C[N-1][N-1].
- mac_cycles  out  16  number of MAC cycles used by the last or current job; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - busy, done, in_ready, out_valid, out_last all 0.
  - out_data = 0, mac_cycles = 0.
  - Register arrays are not cleared.
- IDLE: start=1 -> LOAD on the next edge; mac_cycles cleared to 0; load index cleared.
- LOAD: in_ready=1.
  - Each in_valid&&in_ready beat writes the element at load index and increments the index.
  - After beat 2*N*N-1 -> COMPUTE with r=c=k=0 and acc=0.
  - in_valid low stalls with no timeout.
- COMPUTE: each cycle acc += A[r][k]*B[k][c], k++, and mac_cycles++ (saturating).
  - After the k=N-1 term -> OUTPUT with out_data = final sum.
  - Products are DW x DW -> 2*DW, zero-extended to AW; overflow is impossible by construction of AW.
- OUTPUT: out_valid=1; out_data and out_last are held stable until out_valid&&out_ready.
  - On acceptance: if (r,c)=(N-1,N-1) -> IDLE with a done pulse the same cycle; else advance c (wrap to 0 and r++) -> COMPUTE with acc=0, k=0.
  - out_valid is never dropped without acceptance.
- Latency with out_ready held high:
  - Load = 2*N*N beats.
  - Each element = N compute cycles + 1 output cycle.
  - N=3: 27 MAC cycles, 36 cycles from first compute to done.
- start while busy: ignored, with no effect on the job.
- rst mid-job: job abandoned; next job requires a fresh start and a full reload.
- mac_cycles holds its value after done until the next accepted start.

Optional Feature:
- Macro: MATMUL_ZERO_SKIP_EN.
- When defined:
  - On entering COMPUTE for row r, a nonzero mask of A[r][*] is used.
  - k jumps via priority encoder to the next nonzero index; zero A terms cost no cycle.
  - A row with all zeros spends exactly one COMPUTE cycle, adds nothing and produces 0.
  - mac_cycles counts actual cycles, so per element max(1, nnz(A row r)).
- When undefined: dense schedule of N cycles per element.
- Results are identical in both builds; the port list is unchanged.

Decomposition:
- Package matmul_pkg holds:
  - State enum {IDLE, LOAD, COMPUTE, OUTPUT}.
  - Default N/DW constants.
  - Function acc_width(n,dw).
- Natural sub-module: matmul_mac_unit.
  - Registered accumulator with clear, enable and multiply-add.
  - Parameters DW and AW.
- The engine keeps the FSM, index counters, operand arrays and the skip encoder.

Test Plan:
- N=3, A=identity, B=1..9 row-major, out_ready=1 -> outputs 1..9 in order; out_last on the 9th; done one cycle; mac_cycles=27 (dense build).
- A all 255, B all 255 -> every out_data=195075 (18-bit, no truncation).
- A all 2, B all 3; out_ready toggled 1-0-0-1 pseudo-randomly -> nine outputs of 18, data stable while stalled, no duplicates or drops.
- in_valid gaps during LOAD plus a start pulse mid-compute -> results unaffected, second start ignored, busy continuous.
- Assert rst during COMPUTE after 4 results -> all outputs return to reset values immediately; next start with reload yields the correct full result set.
- MATMUL_ZERO_SKIP_EN, A=diag(1,2,3), B=1..9 -> outputs 1,2,3,8,10,12,21,24,27; mac_cycles=9 (dense build gives 27 with identical data).
